reg_serializer: RTL and testbench

Parallel-in, serial-out transmitter that drives the serial side of a REG-style shift register. It accepts a W-bit word through a valid/ready handshake and emits it one bit per cycle on D0, together with the matching 2-bit shift code. After W shift cycles, the downstream REG holds exactly the transmitted word. It sits between the ALU operand/result path and any REG loaded serially.

---
 rtl/reg_serializer.sv | 115 +++++++++++
 tb/tb_reg_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_serializer.sv
// rtl/reg_serializer.sv - parallel-in serial-out driver for a REG-style shift register
module reg_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_dir,
    input  logic         hold,
    output logic [1:0]   shift,
    output logic         D0,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] CODE_IDLE  = 2'b00;
    localparam logic [1:0] CODE_LEFT  = 2'b01;
    localparam logic [1:0] CODE_RIGHT = 2'b10;

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          dir_q, dir_d;

    // Next-state: capture on accept, rotate the outgoing bit away on each unheld shift cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold) begin
                    // Rotation (not shift) keeps the word intact inside the transmitter
                    if (dir_q) begin
                        data_d = {data_q[0], data_q[W-1:1]};
                    end else begin
                        data_d = {data_q[W-2:0], data_q[W-1]};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
        end
    end

    // Outputs decode directly from registered state so reset silences them without a clock
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        shift    = CODE_IDLE;
        D0       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                D0   = dir_q ? data_q[0] : data_q[W-1];
                if (!hold) begin
                    shift = dir_q ? CODE_RIGHT : CODE_LEFT;
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_reg_serializer.sv
// tb/tb_reg_serializer.sv - directed self-checking bench for reg_serializer
module tb_reg_serializer;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic       hold;
    logic [1:0] shift;
    logic       D0;
    logic       busy;
    logic       done;

    logic [7:0] ref_q;
    int checks;
    int errors;

    reg_serializer #(.W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .hold     (hold),
        .shift    (shift),
        .D0       (D0),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference downstream REG following the receiver contract
    always @(posedge clk) begin
        if (shift == 2'b01) ref_q <= {ref_q[6:0], D0};
        else if (shift == 2'b10) ref_q <= {D0, ref_q[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " shift"}, 32'(shift), 32'd0);
        chk({tag, " D0"}, 32'(D0), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Sends one word with no hold, checks every bit, the done pulse and the received word
    task automatic run_word(input string tag, input logic [7:0] w, input logic d, input logic [7:0] bits);
        logic [1:0] code;
        code = d ? 2'b10 : 2'b01;
        in_data  = w;
        in_dir   = d;
        in_valid = 1'b1;
        chk({tag, " ready before"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk({tag, " shift"}, 32'(shift), 32'(code));
            chk({tag, " D0"}, 32'(D0), 32'(bits[7-i]));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            step();
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " done shift"}, 32'(shift), 32'd0);
        chk({tag, " done ready"}, 32'(in_ready), 32'd0);
        chk({tag, " Q"}, 32'(ref_q), 32'(w));
        step();
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ref_q    = 8'h00;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_dir   = 1'b0;
        hold     = 1'b0;

        // 1: reset values, then a second reset while idle
        #25 reset = 1'b0;
        step();
        chk_idle("t1 reset");
        reset = 1'b1;
        #2;
        chk_idle("t1 rereset");
        reset = 1'b0;
        step();
        chk_idle("t1 after");

        // 2: left shift, MSB first; bit list written out by hand
        run_word("t2", 8'b11101011, 1'b0, 8'b11101011);

        // 3: right shift, LSB first: 1,0,0,1,1,0,1,0
        run_word("t3", 8'b01011001, 1'b1, 8'b10011010);

        // 4: hold for 3 cycles while the 4th bit (0) is presented
        in_data  = 8'b11101011;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t4 bit1", 32'(D0), 32'd1); step();
        chk("t4 bit2", 32'(D0), 32'd1); step();
        chk("t4 bit3", 32'(D0), 32'd1); step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4 hold shift", 32'(shift), 32'd0);
            chk("t4 hold D0", 32'(D0), 32'd0);
            chk("t4 hold busy", 32'(busy), 32'd1);
            step();
        end
        hold = 1'b0;
        #1;
        chk("t4 bit4 shift", 32'(shift), 32'd1);
        chk("t4 bit4", 32'(D0), 32'd0); step();
        chk("t4 bit5", 32'(D0), 32'd1); step();
        chk("t4 bit6", 32'(D0), 32'd0); step();
        chk("t4 bit7", 32'(D0), 32'd1); step();
        chk("t4 bit8", 32'(D0), 32'd1);
        chk("t4 bit8 busy", 32'(done), 32'd0); step();
        chk("t4 done", 32'(done), 32'd1);
        chk("t4 Q", 32'(ref_q), 32'hEB);
        step();
        chk("t4 ready", 32'(in_ready), 32'd1);

        // 5: in_valid stays high with junk data during the transfer; then a back-to-back word
        in_data  = 8'hA5;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t5 A5 D0", 32'(D0), (i == 0 || i == 2 || i == 5 || i == 7) ? 32'd1 : 32'd0);
            chk("t5 A5 shift", 32'(shift), 32'd1);
            in_data = 8'($urandom);
            in_dir  = 1'($urandom);
            step();
        end
        chk("t5 A5 done", 32'(done), 32'd1);
        chk("t5 A5 Q", 32'(ref_q), 32'hA5);
        in_data = 8'h3C;
        in_dir  = 1'b1;
        step();
        chk("t5 gap ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t5 3C D0", 32'(D0), (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
            chk("t5 3C shift", 32'(shift), 32'd2);
            step();
        end
        chk("t5 3C done", 32'(done), 32'd1);
        chk("t5 3C Q", 32'(ref_q), 32'h3C);
        step();

        // 6: asynchronous reset after the 5th bit
        in_data  = 8'hFF;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6 pre busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6 async shift", 32'(shift), 32'd0);
        chk("t6 async busy", 32'(busy), 32'd0);
        chk("t6 async ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6 no done", 32'(done), 32'd0);
        end
        chk_idle("t6 idle");
        run_word("t6 next", 8'h96, 1'b0, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
